// File: rtl/div_iter_if.sv
// div_iter_if
//   Operand/result handshake bundle for div_iter.
//   Operand side : in_valid, in_ready, dividend, divisor
//   Result side  : out_valid, out_ready, quotient, remainder,
//                  div_by_zero, overflow
//   slave  modport: the divider itself
//   master modport: the block feeding operands and consuming results
interface div_iter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] quotient;
  logic [DATA_WIDTH-1:0] remainder;
  logic                  div_by_zero;
  logic                  overflow;

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/div_iter.sv
// div_iter
//   Iterative signed divider, one quotient bit per cycle (restoring
//   shift-subtract). Result = (dividend * 2^FRAC_BITS) / divisor, truncated
//   toward zero and saturated to the signed DATA_WIDTH range. Remainder
//   carries the sign of the dividend. Divide by zero is flagged and returns
//   the saturated value in the direction of the dividend.
//
//   Ports
//     clock : rising-edge clock
//     reset : asynchronous, active-high reset
//     bus   : div_iter_if.slave (operand and result handshakes)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for operands (in_ready=1)
//   INIT  | derive signs/magnitudes from latched operands; zero divisor
//         | goes straight to DONE with the divide-by-zero result
//   ITER  | N shift-subtract steps, counter N-1 down to 0
//   FIX   | apply sign, saturate, register the result
//   DONE  | out_valid=1, held until out_ready
module div_iter #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 0
) (
  input  logic      clock,
  input  logic      reset,
  div_iter_if.slave bus
);

  localparam int N     = DATA_WIDTH + FRAC_BITS;
  localparam int CNT_W = $clog2(N);

  localparam logic [DATA_WIDTH-1:0] Q_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] Q_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] mag_b;
  logic [N-1:0]          num;
  logic [N-1:0]          qmag;
  logic [DATA_WIDTH-1:0] rem_acc;
  logic [CNT_W-1:0]      cnt;
  logic                  q_neg;
  logic                  r_neg;

  logic [DATA_WIDTH-1:0] quotient_r;
  logic [DATA_WIDTH-1:0] remainder_r;
  logic                  div_by_zero_r;
  logic                  overflow_r;

  // magnitudes are unsigned DATA_WIDTH bits, so the most negative operand
  // maps to 2^(DATA_WIDTH-1) exactly
  logic [DATA_WIDTH-1:0] mag_a_c;
  logic [DATA_WIDTH-1:0] mag_b_c;
  logic [N-1:0]          num_init;
  logic                  divisor_zero;

  logic [DATA_WIDTH:0]   rem_shift;
  logic [DATA_WIDTH:0]   rem_sub;
  logic                  rem_fits;

  logic [N-1:0]          lim_pos;
  logic [N-1:0]          lim_neg;
  logic                  sat;
  logic [DATA_WIDTH-1:0] q_fix;
  logic [DATA_WIDTH-1:0] r_fix;

  assign mag_a_c      = op_a[DATA_WIDTH-1] ? (~op_a + 1'b1) : op_a;
  assign mag_b_c      = op_b[DATA_WIDTH-1] ? (~op_b + 1'b1) : op_b;
  assign num_init     = N'(mag_a_c) << FRAC_BITS;
  assign divisor_zero = (op_b == '0);

  // partial remainder stays below |divisor| <= 2^(DATA_WIDTH-1) between
  // steps, so only the shifted value needs the extra bit
  assign rem_shift = {rem_acc, num[N-1]};
  assign rem_fits  = (rem_shift >= {1'b0, mag_b});
  assign rem_sub   = rem_shift - {1'b0, mag_b};

  // the negative range reaches one further than the positive range
  assign lim_pos = N'(Q_MAX);
  assign lim_neg = N'(Q_MIN);
  assign sat     = q_neg ? (qmag > lim_neg) : (qmag > lim_pos);

  always_comb begin
    q_fix = qmag[DATA_WIDTH-1:0];
    if (sat) begin
      q_fix = q_neg ? Q_MIN : Q_MAX;
    end else if (q_neg) begin
      q_fix = ~qmag[DATA_WIDTH-1:0] + 1'b1;
    end
  end

  assign r_fix = r_neg ? (~rem_acc + 1'b1) : rem_acc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (bus.in_valid) state_next = INIT;
      INIT: state_next = divisor_zero ? DONE : ITER;
      ITER: if (cnt == '0) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_a          <= '0;
      op_b          <= '0;
      mag_b         <= '0;
      num           <= '0;
      qmag          <= '0;
      rem_acc       <= '0;
      cnt           <= '0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      quotient_r    <= '0;
      remainder_r   <= '0;
      div_by_zero_r <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_a <= bus.dividend;
            op_b <= bus.divisor;
          end
        end
        INIT: begin
          q_neg   <= op_a[DATA_WIDTH-1] ^ op_b[DATA_WIDTH-1];
          r_neg   <= op_a[DATA_WIDTH-1];
          mag_b   <= mag_b_c;
          num     <= num_init;
          qmag    <= '0;
          rem_acc <= '0;
          cnt     <= CNT_W'(N - 1);
          if (divisor_zero) begin
            quotient_r    <= op_a[DATA_WIDTH-1] ? Q_MIN : Q_MAX;
            remainder_r   <= op_a;
            div_by_zero_r <= 1'b1;
            overflow_r    <= 1'b0;
          end
        end
        ITER: begin
          num  <= {num[N-2:0], 1'b0};
          qmag <= {qmag[N-2:0], rem_fits};
          cnt  <= cnt - CNT_W'(1);
          if (rem_fits) begin
            rem_acc <= rem_sub[DATA_WIDTH-1:0];
          end else begin
            rem_acc <= rem_shift[DATA_WIDTH-1:0];
          end
        end
        FIX: begin
          quotient_r    <= q_fix;
          remainder_r   <= r_fix;
          div_by_zero_r <= 1'b0;
          overflow_r    <= sat;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = div_by_zero_r;
  assign bus.overflow    = overflow_r;

endmodule
